// File: rtl/clock_enable.sv
// clock_enable: derives every phase-aligned strobe of the Lynx core from the
// 48 MHz system clock. A 48-state phase counter is the common reference. A
// startup hold keeps all strobes quiet until the design has settled. The CPU
// strobes run at 4 or 6 MHz and can be stretched by the Z80 WAIT request.
module clock_enable #(
    parameter int STARTUP = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic turbo,
    input  logic wait_n,
    output logic ready,
    output logic ce12,
    output logic pe6,
    output logic ne6,
    output logic cpu_pe,
    output logic cpu_ne,
    output logic ce1
);

    localparam int SU_W = $clog2(STARTUP + 1);
    localparam logic [SU_W-1:0] SU_MAX = SU_W'(STARTUP);

    typedef struct packed {
        logic ce12;
        logic pe6;
        logic ne6;
        logic cpu_pe;
        logic cpu_ne;
        logic ce1;
    } strobes_t;

    logic [5:0]      c_q, c_d;
    logic [SU_W-1:0] su_q, su_d;
    logic            t_q, t_d;
    logic            h_q, h_d;
    logic            ready_q, ready_d;
    strobes_t        st_q, st_d;
    logic            raw_pe, raw_ne;

    // Next-state logic. Strobes are decoded from the *next* phase value so
    // the registered outputs are high in the cycle where the phase holds.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        c_d     = (c_q == 6'd47) ? 6'd0 : c_q + 6'd1;
        su_d    = (su_q == SU_MAX) ? su_q : su_q + 1'b1;
        t_d     = (c_q == 6'd47) ? turbo : t_q;
        ready_d = ready_q | ((c_d == 6'd0) && (su_d == SU_MAX));
        h_d     = h_q;
        st_d    = '0;

        // Raw CPU phases follow the speed that will apply in the next cycle,
        // so a turbo change sampled at c==47 takes effect exactly at c==0.
        raw_pe = t_d ? (c_d[2:0] == 3'd0) : ((c_d % 6'd12) == 6'd0);
        raw_ne = t_d ? (c_d[2:0] == 3'd4) : ((c_d % 6'd12) == 6'd6);

        if (ready_d) begin
            st_d.ce12   = (c_d[1:0] == 2'd0);
            st_d.pe6    = (c_d[2:0] == 3'd0);
            st_d.ne6    = (c_d[2:0] == 3'd4);
            st_d.ce1    = (c_d == 6'd0);
            st_d.cpu_pe = raw_pe && !h_q;
            // The hold flag only changes on raw falling phases. A falling
            // phase fires only when not already held; a held falling phase
            // with WAIT released is swallowed so the next rising phase
            // resumes the CPU cleanly.
            if (raw_ne) begin
                st_d.cpu_ne = !h_q;
                h_d         = !wait_n;
            end
        end
    end

    // State and output registers; reset clears every output immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            c_q     <= '0;
            su_q    <= '0;
            t_q     <= 1'b0;
            h_q     <= 1'b0;
            ready_q <= 1'b0;
            st_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register update from
            // the values of the previous cycle, independent of statement order.
            c_q     <= c_d;
            su_q    <= su_d;
            t_q     <= t_d;
            h_q     <= h_d;
            ready_q <= ready_d;
            st_q    <= st_d;
        end
    end

    assign ready  = ready_q;
    assign ce12   = st_q.ce12;
    assign pe6    = st_q.pe6;
    assign ne6    = st_q.ne6;
    assign cpu_pe = st_q.cpu_pe;
    assign cpu_ne = st_q.cpu_ne;
    assign ce1    = st_q.ce1;

endmodule

// File: tb/tb_clock_enable.sv
// Directed testbench for clock_enable with STARTUP=16. It tracks the phase by
// counting clock edges since reset release, and checks on the falling edge.
module tb_clock_enable;

    logic clock = 1'b0;
    logic reset, turbo, wait_n;
    logic ready, ce12, pe6, ne6, cpu_pe, cpu_ne, ce1;
    logic [6:0] outs;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int cc      = 0;
    int n_ce1, n_ce12, n_pe6, n_ne6, n_cpe, n_cne;
    int last;

    clock_enable #(.STARTUP(16)) dut (
        .clock  (clock),
        .reset  (reset),
        .turbo  (turbo),
        .wait_n (wait_n),
        .ready  (ready),
        .ce12   (ce12),
        .pe6    (pe6),
        .ne6    (ne6),
        .cpu_pe (cpu_pe),
        .cpu_ne (cpu_ne),
        .ce1    (ce1)
    );

    always #5 clock = ~clock;

    assign outs = {ready, ce12, pe6, ne6, cpu_pe, cpu_ne, ce1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at c=%0d: observed %0h expected %0h", tag, cc, obs, exp);
        end
    endtask

    // One clock edge, then return just after the falling edge for sampling.
    task automatic tick();
        @(posedge clock);
        cyc++;
        cc = cyc % 48;
        @(negedge clock);
    endtask

    // n cycles checking CPU strobes against the hand-given speed (0=4, 1=6 MHz).
    task automatic tick_spd(input int n, input bit spd);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("spd_cpu_pe", cpu_pe, spd ? (cc % 8 == 0) : (cc % 12 == 0));
            chk("spd_cpu_ne", cpu_ne, spd ? (cc % 8 == 4) : (cc % 12 == 6));
        end
    endtask

    // n cycles each expecting the given fixed CPU strobe values.
    task automatic tick_exp(input string tag, input int n, input bit pe, input bit ne);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, "_pe"}, cpu_pe, pe);
            chk({tag, "_ne"}, cpu_ne, ne);
        end
    endtask

    // Reset release followed by the full startup hold and alignment.
    task automatic release_and_startup(input string tag);
        reset = 1'b1;
        cyc   = 0;
        cc    = 0;
        for (int i = 0; i < 47; i++) begin
            tick();
            chk({tag, "_quiet"}, outs, 7'b0);
        end
        tick();
        // ready, ce12, pe6, cpu_pe and ce1 together at c==0.
        chk({tag, "_first_frame"}, outs, 7'b1110101);
    endtask

    initial begin
        reset  = 1'b0;
        turbo  = 1'b0;
        wait_n = 1'b1;
        tick();
        tick();
        chk("reset_state", outs, 7'b0);

        // Startup hold.
        release_and_startup("startup");

        // Rates over ten frames at 4 MHz.
        n_ce1 = 0; n_ce12 = 0; n_pe6 = 0; n_ne6 = 0; n_cpe = 0; n_cne = 0;
        for (int i = 0; i < 480; i++) begin
            tick();
            n_ce1  += int'(ce1);
            n_ce12 += int'(ce12);
            n_pe6  += int'(pe6);
            n_ne6  += int'(ne6);
            n_cpe  += int'(cpu_pe);
            n_cne  += int'(cpu_ne);
            chk("rate_pattern", outs, {1'b1, cc % 4 == 0, cc % 8 == 0, cc % 8 == 4,
                                       cc % 12 == 0, cc % 12 == 6, cc == 0});
        end
        chk("count_ce1", n_ce1, 10);
        chk("count_ce12", n_ce12, 120);
        chk("count_pe6", n_pe6, 60);
        chk("count_ne6", n_ne6, 60);
        chk("count_cpu_pe", n_cpe, 40);
        chk("count_cpu_ne", n_cne, 40);

        // Turbo switch at c==20: rest of the frame stays 4 MHz.
        tick_spd(20, 1'b0);
        turbo = 1'b1;
        tick_spd(27, 1'b0);
        // Next frame at 6 MHz; drop turbo at c==10 (effective next frame).
        tick_spd(11, 1'b1);
        turbo = 1'b0;
        tick_spd(37, 1'b1);
        // 4 MHz frame with a turbo pulse over c in [30,40]: no speed change.
        tick_spd(31, 1'b0);
        turbo = 1'b1;
        tick_spd(11, 1'b0);
        turbo = 1'b0;
        tick_spd(6, 1'b0);
        tick_spd(48, 1'b0);

        // Wait: request before c==6, release at c==25.
        tick_spd(6, 1'b0);
        wait_n = 1'b0;
        tick_exp("wait_ne6", 1, 1'b0, 1'b1);
        tick_exp("wait_held", 19, 1'b0, 1'b0);
        wait_n = 1'b1;
        tick_exp("wait_swallow", 10, 1'b0, 1'b0);
        tick_exp("wait_pe36", 1, 1'b1, 1'b0);
        tick_exp("wait_gap", 5, 1'b0, 1'b0);
        tick_exp("wait_ne42", 1, 1'b0, 1'b1);

        // Reset mid-operation at c==17 with the hold flag set.
        tick_exp("pre_rst_gap", 5, 1'b0, 1'b0);
        tick_exp("pre_rst_pe0", 1, 1'b1, 1'b0);
        wait_n = 1'b0;
        tick_exp("pre_rst_gap2", 5, 1'b0, 1'b0);
        tick_exp("pre_rst_ne6", 1, 1'b0, 1'b1);
        tick_exp("pre_rst_held", 11, 1'b0, 1'b0);
        #1 reset = 1'b0;
        #1 chk("reset_async", outs, 7'b0);
        wait_n = 1'b1;
        tick();
        tick();
        chk("reset_held", outs, 7'b0);
        release_and_startup("restart");
        tick_exp("restart_gap", 5, 1'b0, 1'b0);
        tick_exp("restart_ne6", 1, 1'b0, 1'b1);

        // Steady state with random turbo and wait_n.
        last = 2;
        for (int i = 0; i < 10000; i++) begin
            turbo  = 1'($urandom_range(0, 1));
            wait_n = ($urandom_range(0, 3) != 0);
            tick();
            chk("rand_coincide", cpu_pe & cpu_ne, 1'b0);
            chk("rand_gated", (cpu_pe | cpu_ne) & ~ready, 1'b0);
            if (cpu_pe) begin
                chk("rand_alt_pe", last, 2);
                last = 1;
            end
            if (cpu_ne) begin
                chk("rand_alt_ne", last, 1);
                last = 2;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
